hgcal_input_packer: RTL and testbench
=====================================

Name: hgcal_input_packer

Overview:
- Upstream feeder for the first LogicNets layer of the HGCAL autoencoder.
- Accepts a stream of unsigned trigger-cell charge samples, one per handshake, and quantizes each to a 2-bit code against three fixed thresholds.
- Packs NUM_IN codes into one flat frame vector and presents it, registered, on a valid/ready output.
- The output bus feeds the layer-0 neuron input slices directly; each neuron takes 8-bit slices formed from four 2-bit codes.

Parameters:
- IN_W, 8, width of one input sample (unsigned).
- NUM_IN, 48, samples per frame.
- Q_W, 2, code width per sample. Fixed at 2; any other value is rejected at elaboration.
- THR1, 32, lower threshold.
- THR2, 64, middle threshold.
- THR3, 128, upper threshold. Elaboration check: THR1 < THR2 < THR3 < 2**IN_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-high; clears all state.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_data  in  IN_W  charge sample.
- s_last  in  1  marks the final sample of a frame.
- m_valid  out  1  packed frame valid.
- m_ready  in  1  downstream accepts the frame.
- m_data  out  NUM_IN*Q_W  packed codes; sample k sits at bits [k*Q_W +: Q_W]; sample 0 in the LSBs.
- err  out  1  sticky frame-framing error.

Behaviour:
- Quantization: code = 0 if x<THR1; 1 if x<THR2; 2 if x<THR3; else 3. Compare unsigned at full IN_W; no rounding.
- Storage: index counter idx (0..NUM_IN-1), assembly register asm_q, output register out_q with flag m_valid.
- States:
  - FILL: s_ready=1. Each accepted sample writes its code to asm_q slot idx, then idx++.
  - HOLD: s_ready=0. asm_q is complete and waiting for out_q to free.
- Frame completion: a sample accepted at idx=NUM_IN-1 completes the frame.
  - If out_q is empty, or out_q is being drained this cycle (m_valid & m_ready), the frame (including this last code) loads into out_q at the same edge. m_valid=1 next cycle and idx returns to 0. This is 1-cycle latency from the last sample to m_valid.
  - Otherwise go to HOLD. Exit HOLD on the edge where m_valid & m_ready: asm_q moves to out_q, m_valid stays 1, idx=0, state returns to FILL.
- Throughput: back-to-back frames incur no bubble while downstream drains every cycle.
- Output handshake: m_data is stable while m_valid & !m_ready. m_valid drops after the handshake unless a new frame loads at that same edge.
- Framing:
  - Early s_last (accepted at idx<NUM_IN-1): discard the partial frame, idx=0, set err. Nothing is emitted.
  - Missing s_last at idx=NUM_IN-1: the frame is still emitted and err is set.
- err is sticky; only rst clears it.
- Reset values: s_ready=0 during rst, 1 in the first cycle after release. m_valid=0, m_data=0, err=0, idx=0, asm_q=0, state=FILL.
- Reset mid-frame: the partial frame and any pending output are lost; no output is asserted afterwards until a new complete frame arrives.
- While s_valid=0: no state change. s_data and s_last are ignored unless s_valid & s_ready.

Optional Feature:
- Macro HGCAL_INPUT_PACKER_SATCNT_EN.
- Defined: adds output port sat_cnt (16 bits). It increments once for each accepted sample quantized to code 3, saturates at 16'hFFFF, and rst clears it to 0. Samples from discarded frames still count.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package hgcal_pack_pkg holds:
  - localparam Q_W=2.
  - typedef logic [1:0] qcode_t.
  - default threshold constants THR1_DEF, THR2_DEF, THR3_DEF.
  - function quantize() implementing the compare chain.
- Sub-module hgcal_quantizer: combinational, IN_W in, qcode_t out, threshold parameters. Instantiated once on s_data.
- The FSM, counter, and registers stay in the top.

Test Plan:
- Basic pack: NUM_IN=4, THR 32/64/128. Samples 10, 40, 100, 200 with s_last on the 4th, m_ready=1 -> m_valid one cycle after the 4th sample, m_data=8'hE4, err=0.
- Threshold edges: NUM_IN=4. Samples 31, 32, 127, 128 -> m_data=8'b11_10_01_00 (0xE4 with 31→0, 32→1, 127→2, 128→3).
- Backpressure: m_ready=0. Send two frames (0xE4 pattern, then all 255) -> the first stays on m_data, s_ready=0 after the second completes. Raise m_ready -> 0xE4 then 0xFF on consecutive cycles. No sample lost.
- Early s_last: NUM_IN=4. s_last on the 2nd sample -> no m_valid, err=1 and stays 1. The next clean frame emits correctly.
- Reset mid-frame: assert rst after 2 of 4 samples -> m_valid=0, err=0. Then 4 samples of value 0 -> m_data=8'h00 emitted.
- SATCNT_EN build: 70000 samples of value 255 -> sat_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/hgcal_pack_pkg.sv
// Shared types, defaults and the threshold compare chain for the HGCAL input packer.
package hgcal_pack_pkg;

    localparam int unsigned Q_W      = 2;
    localparam int unsigned THR1_DEF = 32;
    localparam int unsigned THR2_DEF = 64;
    localparam int unsigned THR3_DEF = 128;

    typedef logic [1:0] qcode_t;

    // Unsigned full-width compare chain: below THR1 -> 0 ... at/above THR3 -> 3.
    function automatic qcode_t quantize(input logic [31:0] x,
                                        input logic [31:0] t1,
                                        input logic [31:0] t2,
                                        input logic [31:0] t3);
        qcode_t q;
        if (x < t1)      q = 2'd0;
        else if (x < t2) q = 2'd1;
        else if (x < t3) q = 2'd2;
        else             q = 2'd3;
        return q;
    endfunction

endpackage

// File: rtl/hgcal_quantizer.sv
// Combinational 2-bit quantizer of one unsigned charge sample against three thresholds.
module hgcal_quantizer
    import hgcal_pack_pkg::*;
#(
    parameter int unsigned IN_W = 8,
    parameter int unsigned THR1 = THR1_DEF,
    parameter int unsigned THR2 = THR2_DEF,
    parameter int unsigned THR3 = THR3_DEF
) (
    input  logic [IN_W-1:0] sample,
    output qcode_t          code_c
);

    assign code_c = quantize(32'(sample), 32'(THR1), 32'(THR2), 32'(THR3));

endmodule

// File: rtl/hgcal_input_packer.sv
// Quantizes a sample stream to 2-bit codes and packs NUM_IN codes per registered output frame.
// Optional build macro HGCAL_INPUT_PACKER_SATCNT_EN adds a saturating code-3 counter port sat_cnt.
module hgcal_input_packer
    import hgcal_pack_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned NUM_IN = 48,
    parameter int unsigned Q_W    = hgcal_pack_pkg::Q_W,
    parameter int unsigned THR1   = THR1_DEF,
    parameter int unsigned THR2   = THR2_DEF,
    parameter int unsigned THR3   = THR3_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_W-1:0]       s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [NUM_IN*Q_W-1:0] m_data,
`ifdef HGCAL_INPUT_PACKER_SATCNT_EN
    output logic [15:0]           sat_cnt,
`endif
    output logic                  err
);

    localparam int unsigned DATA_W = NUM_IN * Q_W;
    localparam int unsigned IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    if (Q_W != 2) begin : g_bad_q_w
        $error("hgcal_input_packer: Q_W must be 2");
    end
    if (IN_W == 0 || IN_W > 32) begin : g_bad_in_w
        $error("hgcal_input_packer: IN_W must be 1..32");
    end
    if (NUM_IN == 0) begin : g_bad_num_in
        $error("hgcal_input_packer: NUM_IN must be at least 1");
    end
    if (!(THR1 < THR2 && THR2 < THR3 && 64'(THR3) < (64'd1 << IN_W))) begin : g_bad_thr
        $error("hgcal_input_packer: thresholds must satisfy THR1 < THR2 < THR3 < 2**IN_W");
    end

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [DATA_W-1:0]  asm_q, asm_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic               m_valid_d;
    logic               err_d;
    qcode_t             code_c;
    logic               accept;
    logic               last_slot;
    logic               out_free;

    hgcal_quantizer #(
        .IN_W (IN_W),
        .THR1 (THR1),
        .THR2 (THR2),
        .THR3 (THR3)
    ) u_quantizer (
        .sample (s_data),
        .code_c (code_c)
    );

    // Ready follows the FILL state but is forced low while reset is held.
    assign s_ready   = (state == S_FILL) && !rst;
    assign accept    = s_valid && s_ready;
    assign last_slot = (idx == IDX_W'(NUM_IN - 1));
    assign out_free  = !m_valid || m_ready;
    assign m_data    = out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FILL;
            idx     <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            m_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            m_valid <= m_valid_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        asm_d     = asm_q;
        out_d     = out_q;
        m_valid_d = m_valid && !m_ready;
        err_d     = err;

        case (state)
            S_FILL: begin
                if (accept) begin
                    asm_d[idx*Q_W +: Q_W] = code_c;
                    if (last_slot) begin
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                        // Load straight into the output when it is empty or draining now.
                        if (out_free) begin
                            out_d     = asm_d;
                            m_valid_d = 1'b1;
                            idx_d     = '0;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else if (s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                        asm_d = '0;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (m_valid && m_ready) begin
                    out_d     = asm_q;
                    m_valid_d = 1'b1;
                    idx_d     = '0;
                    state_d   = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

`ifdef HGCAL_INPUT_PACKER_SATCNT_EN
    // Counts every accepted code-3 sample, including those of discarded frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (accept && code_c == qcode_t'(3) && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Scoreboard bench for hgcal_input_packer with NUM_IN=4 and thresholds 32/64/128.
module tb_hgcal_input_packer;

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned DW     = NUM_IN * 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          err;
`ifdef HGCAL_INPUT_PACKER_SATCNT_EN
    logic [15:0]   sat_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    hgcal_input_packer #(
        .IN_W   (8),
        .NUM_IN (NUM_IN),
        .Q_W    (2),
        .THR1   (32),
        .THR2   (64),
        .THR3   (128)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
`ifdef HGCAL_INPUT_PACKER_SATCNT_EN
        .sat_cnt (sat_cnt),
`endif
        .err     (err)
    );

    always #5 clk = ~clk;

    // Monitor: every output handshake pops one expected frame.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected: got m_data=%h, no frame expected", m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL frame_data: got m_data=%h, expected %h", m_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold one sample on the bus until it is accepted, bounded by a cycle budget.
    task automatic send(input logic [7:0] d, input logic l);
        logic acc;
        int   n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        acc = 1'b0;
        while (!acc) begin
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 50) begin
                errors++;
                checks++;
                $display("FAIL send_timeout: s_ready stayed %b, expected 1", s_ready);
                acc = 1'b1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic l);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, l);
    endtask

    initial begin
        tick(2);
        chk("reset_s_ready", 32'(s_ready), 32'd0);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data",  32'(m_data),  32'd0);
        chk("reset_err",     32'(err),     32'd0);
        rst = 1'b0;
        #1;
        chk("release_s_ready", 32'(s_ready), 32'd1);

        // Basic pack: codes 0,1,2,3 -> E4, valid one cycle after the last sample.
        exp_q.push_back(8'hE4);
        send4(8'd10, 8'd40, 8'd100, 8'd200, 1'b1);
        chk("basic_latency_m_valid", 32'(m_valid), 32'd1);
        chk("basic_m_data", 32'(m_data), 32'hE4);
        chk("basic_err", 32'(err), 32'd0);
        tick(1);
        chk("basic_m_valid_drop", 32'(m_valid), 32'd0);

        // Threshold edges.
        exp_q.push_back(8'hE4);
        send4(8'd31, 8'd32, 8'd127, 8'd128, 1'b1);
        tick(2);

        // Backpressure: second frame parks in HOLD behind the first.
        m_ready = 1'b0;
        exp_q.push_back(8'hE4);
        exp_q.push_back(8'hFF);
        send4(8'd31, 8'd32, 8'd127, 8'd128, 1'b1);
        send4(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        chk("bp_s_ready_hold", 32'(s_ready), 32'd0);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        tick(3);
        chk("bp_m_data_stable", 32'(m_data), 32'hE4);
        chk("bp_s_ready_still", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        tick(1);
        chk("bp_second_valid", 32'(m_valid), 32'd1);
        chk("bp_second_data", 32'(m_data), 32'hFF);
        chk("bp_s_ready_back", 32'(s_ready), 32'd1);
        tick(1);
        chk("bp_drained", 32'(m_valid), 32'd0);

        // Early s_last discards the partial frame and sets err.
        send(8'd10, 1'b0);
        send(8'd40, 1'b1);
        tick(3);
        chk("early_no_output", 32'(m_valid), 32'd0);
        chk("early_err", 32'(err), 32'd1);
        exp_q.push_back(8'h1B);
        send4(8'd200, 8'd100, 8'd40, 8'd10, 1'b1);
        tick(2);
        chk("early_err_sticky", 32'(err), 32'd1);

        // Reset mid-frame, with a frame also pending on the output.
        m_ready = 1'b0;
        send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        send(8'd10, 1'b0);
        send(8'd40, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        tick(1);
        rst = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("midrst_err", 32'(err), 32'd0);
        tick(2);
        chk("midrst_no_output", 32'(m_valid), 32'd0);
        exp_q.push_back(8'h00);
        send4(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        chk("midrst_frame_valid", 32'(m_valid), 32'd1);
        chk("midrst_frame_data", 32'(m_data), 32'h00);
        tick(2);

        // Missing s_last: frame still emitted, err raised.
        exp_q.push_back(8'hFF);
        send4(8'd255, 8'd254, 8'd129, 8'd128, 1'b0);
        chk("nolast_err", 32'(err), 32'd1);
        chk("nolast_valid", 32'(m_valid), 32'd1);
        tick(2);

`ifdef HGCAL_INPUT_PACKER_SATCNT_EN
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        #1;
        chk("sat_reset", 32'(sat_cnt), 32'd0);
        for (int i = 0; i < 70000; i++) begin
            if (i % 4 == 3) exp_q.push_back(8'hFF);
            send(8'd255, (i % 4 == 3));
        end
        tick(2);
        chk("sat_full", 32'(sat_cnt), 32'hFFFF);
        exp_q.push_back(8'hFF);
        send4(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        tick(2);
        chk("sat_hold", 32'(sat_cnt), 32'hFFFF);
`endif

        tick(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
